procesamiento_param: RTL

Parametrised accumulator/ALU processing unit; next generation of the 4-bit single-accumulator datapath. Adds configurable data width, a bank of selectable accumulators, a valid/busy/done operation handshake, and an optional multi-cycle shift-add multiply. Sits between the data bus (data_in, tri-state data_out) and the control unit that issues opcodes.

---
 rtl/procesamiento_param_if.sv | 26 ++
 rtl/procesamiento_param.sv | 137 +++++++++++++
 2 files changed

// File: rtl/procesamiento_param_if.sv
// Operation request / status bundle between the control unit (master) and procesamiento_param (slave).
interface procesamiento_param_if #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 2
);
  logic [WIDTH-1:0] data_in;
  logic [2:0]       control;
  logic [SEL_W-1:0] acc_sel;
  logic             op_valid;
  logic             enable_out_alu;
  logic             busy;
  logic             done;
  logic             illegal;
  logic             C;
  logic             Z;

  modport master (
    output data_in, control, acc_sel, op_valid, enable_out_alu,
    input  busy, done, illegal, C, Z
  );

  modport slave (
    input  data_in, control, acc_sel, op_valid, enable_out_alu,
    output busy, done, illegal, C, Z
  );
endinterface

// File: rtl/procesamiento_param.sv
// Parametrised accumulator-bank ALU with valid/busy/done handshake and tri-state result bus.
// Optional macro PROC_MUL_EN builds the multi-cycle shift-add MUL for opcode 7; without it opcode 7 pulses illegal.
module procesamiento_param #(
  parameter int WIDTH = 4,
  parameter int NACC  = 4,
  parameter int SEL_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  procesamiento_param_if.slave bus,
  output tri   [WIDTH-1:0]     data_out
);
  typedef enum logic [2:0] {
    OP_PASSA = 3'd0,
    OP_SUB   = 3'd1,
    OP_PASSB = 3'd2,
    OP_ADD   = 3'd3,
    OP_NAND  = 3'd4,
    OP_XOR   = 3'd5,
    OP_SHL   = 3'd6,
    OP_MUL   = 3'd7
  } op_e;

  op_e                        op;
  logic [NACC-1:0][WIDTH-1:0] acc;
  logic [WIDTH-1:0]           a, b, res;
  logic                       c_n;
  logic                       c_q, z_q, done_q, illegal_q;
  logic                       busy;
  logic                       accept_alu;

  assign op = op_e'(bus.control);
  assign a  = acc[bus.acc_sel];
  assign b  = bus.data_in;

  // Widen by one bit so the carry (ADD), borrow (SUB) and shifted-out MSB (SHL) fall into c_n.
  always_comb begin
    res = a;
    c_n = 1'b0;
    case (op)
      OP_PASSA: res = a;
      OP_SUB:   {c_n, res} = {1'b0, a} - {1'b0, b};
      OP_PASSB: res = b;
      OP_ADD:   {c_n, res} = {1'b0, a} + {1'b0, b};
      OP_NAND:  res = ~(a & b);
      OP_XOR:   res = a ^ b;
      OP_SHL:   {c_n, res} = {a, 1'b0};
      default:  res = a;
    endcase
  end

  assign data_out = bus.enable_out_alu ? res : {WIDTH{1'bz}};

  assign accept_alu = bus.op_valid && !busy && (op != OP_MUL);

`ifdef PROC_MUL_EN
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e             state;
  logic [WIDTH-1:0]   mcand;
  logic [SEL_W-1:0]   sel_l;
  logic [2*WIDTH-1:0] prod, prod_step;
  logic [WIDTH:0]     upper_sum;
  logic [CNT_W-1:0]   cnt;

  // Right-shifting shift-add: multiplier starts in the low half, partial sum grows in the high half.
  assign upper_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
  assign prod_step = {upper_sum, prod[WIDTH-1:1]};
  assign busy      = (state == S_MUL);
`else
  assign busy      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef PROC_MUL_EN
      state     <= S_IDLE;
      mcand     <= '0;
      sel_l     <= '0;
      prod      <= '0;
      cnt       <= '0;
`endif
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;

      if (accept_alu) begin
        acc[bus.acc_sel] <= res;
        c_q              <= c_n;
        z_q              <= (res == '0);
        done_q           <= 1'b1;
      end

`ifdef PROC_MUL_EN
      case (state)
        S_IDLE: begin
          if (bus.op_valid && op == OP_MUL) begin
            state <= S_MUL;
            mcand <= a;
            sel_l <= bus.acc_sel;
            prod  <= {{WIDTH{1'b0}}, b};
            cnt   <= '0;
          end
        end
        S_MUL: begin
          prod <= prod_step;
          cnt  <= cnt + 1'b1;
          // Last step commits the freshly computed product, not the stale register.
          if (cnt == CNT_W'(WIDTH - 1)) begin
            acc[sel_l] <= prod_step[WIDTH-1:0];
            c_q        <= |prod_step[2*WIDTH-1:WIDTH];
            z_q        <= (prod_step[WIDTH-1:0] == '0);
            done_q     <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
`else
      if (bus.op_valid && op == OP_MUL) illegal_q <= 1'b1;
`endif
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done_q;
  assign bus.illegal = illegal_q;
  assign bus.C       = c_q;
  assign bus.Z       = z_q;
endmodule
